// File: rtl/mux_pkg.sv
// Shared defaults, reset values and selector-width helper for the memory mux.
package mux_pkg;

    localparam int unsigned DEF_WIDTH    = 2;
    localparam int unsigned DEF_CHANNELS = 4;
    localparam int unsigned DEF_CNT_W    = 8;

    localparam logic        RST_VALID    = 1'b0;
    localparam int unsigned RST_SEL      = 0;
    localparam int unsigned RST_MISS     = 0;

    // Selector width for n channels; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// Combinational round-robin grant: first valid channel after ptr, wrapping.
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned CHANNELS = DEF_CHANNELS,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] valid_in,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant_c,
    output logic                found_c
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant_c = '0;
        found_c = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            idx = SEL_W'((32'(ptr) + k) % CHANNELS);
            if (!found_c && valid_in[idx]) begin
                found_c = 1'b1;
                grant_c = idx;
            end
        end
    end

endmodule

// File: rtl/mux_memoria_n.sv
// Registered N-channel mux with memory, valid qualification, freeze and miss counter.
// Round-robin selection is built in when MUX_RR_EN is defined.
module mux_memoria_n
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEF_WIDTH,
    parameter  int unsigned CHANNELS = DEF_CHANNELS,
    parameter  int unsigned CNT_W    = DEF_CNT_W,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic                      hold,
`ifdef MUX_RR_EN
    input  logic                      rr_mode,
`endif
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic [CNT_W-1:0]          miss_cnt
);

    localparam int unsigned      SEL_N    = 2 ** SEL_W;
    localparam logic [CNT_W-1:0] MISS_MAX = '1;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    logic [SEL_N-1:0] valid_ext;
    logic [WIDTH-1:0] chan_c [SEL_N];
    logic             cap_c;
    logic [SEL_W-1:0] cap_idx_c;

    // Pad to a full power-of-two table so out-of-range selectors read as invalid.
    assign valid_ext = SEL_N'(valid_in);

    for (genvar i = 0; i < SEL_N; i++) begin : g_chan
        if (i < CHANNELS) begin : g_real
            assign chan_c[i] = data_in[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan_c[i] = '0;
        end
    end

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] grant_c;
    logic             found_c;

    mux_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .valid_in (valid_in),
        .ptr      (ptr_q),
        .grant_c  (grant_c),
        .found_c  (found_c)
    );
`endif

    // Pick the candidate channel for this edge.
    always_comb begin
        cap_c     = valid_ext[selector];
        cap_idx_c = selector;
`ifdef MUX_RR_EN
        if (rr_mode) begin
            cap_c     = found_c;
            cap_idx_c = grant_c;
        end
`endif
    end

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        miss_d  = miss_q;
`ifdef MUX_RR_EN
        ptr_d   = ptr_q;
`endif
        if (!hold) begin
            if (cap_c) begin
                data_d  = chan_c[cap_idx_c];
                sel_d   = cap_idx_c;
                valid_d = 1'b1;
`ifdef MUX_RR_EN
                if (rr_mode) begin
                    ptr_d = cap_idx_c;
                end
`endif
            end else if (miss_q != MISS_MAX) begin
                miss_d = miss_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= RST_VALID;
            sel_q   <= SEL_W'(RST_SEL);
            miss_q  <= CNT_W'(RST_MISS);
`ifdef MUX_RR_EN
            ptr_q   <= SEL_W'(CHANNELS - 1);
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            miss_q  <= miss_d;
`ifdef MUX_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign sel_out   = sel_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_mux_memoria_n.sv
// Bench for mux_memoria_n: two instances (4ch/CNT_W=2 and 3ch/CNT_W=4) against a behavioural model.
module tb_mux_memoria_n;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] selector;
    logic       hold;
    logic       rr_mode;
    logic [7:0] a_din;
    logic [3:0] a_vin;
    logic [8:0] b_din;
    logic [2:0] b_vin;

    logic [1:0] a_dout, a_sel, a_miss;
    logic       a_vout;
    logic [2:0] b_dout;
    logic [1:0] b_sel;
    logic [3:0] b_miss;
    logic       b_vout;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux_memoria_n #(.WIDTH(2), .CHANNELS(4), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .selector(selector), .data_in(a_din),
        .valid_in(a_vin), .hold(hold),
`ifdef MUX_RR_EN
        .rr_mode(rr_mode),
`endif
        .data_out(a_dout), .valid_out(a_vout), .sel_out(a_sel), .miss_cnt(a_miss)
    );

    mux_memoria_n #(.WIDTH(3), .CHANNELS(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .selector(selector), .data_in(b_din),
        .valid_in(b_vin), .hold(hold),
`ifdef MUX_RR_EN
        .rr_mode(rr_mode),
`endif
        .data_out(b_dout), .valid_out(b_vout), .sel_out(b_sel), .miss_cnt(b_miss)
    );

    typedef struct {
        int data;
        int valid;
        int sel;
        int miss;
        int ptr;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t mreset(int ch);
        mst_t s;
        s.data = 0; s.valid = 0; s.sel = 0; s.miss = 0; s.ptr = ch - 1;
        return s;
    endfunction

    // One clock edge of the mux as described behaviourally.
    function automatic mst_t mstep(mst_t s, int ch, int w, int cmax, int sel,
                                   logic [63:0] din, logic [7:0] vin, bit hld, bit rr);
        mst_t n;
        int   g;
        n = s;
        n.valid = 0;
        g = -1;
        if (hld) return n;
        if (rr) begin
            for (int k = 1; k <= ch; k++) begin
                if (g < 0 && vin[(s.ptr + k) % ch]) g = (s.ptr + k) % ch;
            end
        end else if (sel < ch && vin[sel]) begin
            g = sel;
        end
        if (g >= 0) begin
            n.data  = int'((din >> (g * w)) & ((64'd1 << w) - 64'd1));
            n.valid = 1;
            n.sel   = g;
            if (rr) n.ptr = g;
        end else if (s.miss < cmax) begin
            n.miss = s.miss + 1;
        end
        return n;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit rr_eff();
`ifdef MUX_RR_EN
        return rr_mode;
`else
        return 1'b0;
`endif
    endfunction

    // Advance one edge: update models at the edge, return at the following negedge.
    task automatic cyc();
        @(posedge clk);
        ma = mstep(ma, 4, 2, 3, int'(selector), 64'(a_din), 8'(a_vin), hold, rr_eff());
        mb = mstep(mb, 3, 3, 15, int'(selector), 64'(b_din), 8'(b_vin), hold, rr_eff());
        @(negedge clk);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge.
    task automatic async_reset(input bit lit);
        #2 reset = 1'b1;
        #1;
        ma = mreset(4);
        mb = mreset(3);
        if (lit) begin
            check("rst_data_imm", int'(a_dout), 0);
            check("rst_valid_imm", int'(a_vout), 0);
            check("rst_sel_imm", int'(a_sel), 0);
            check("rst_miss_imm", int'(a_miss), 0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_data", int'(a_dout), ma.data);
            check("a_valid", int'(a_vout), ma.valid);
            check("a_sel", int'(a_sel), ma.sel);
            check("a_miss", int'(a_miss), ma.miss);
            check("b_data", int'(b_dout), mb.data);
            check("b_valid", int'(b_vout), mb.valid);
            check("b_sel", int'(b_sel), mb.sel);
            check("b_miss", int'(b_miss), mb.miss);
        end
    end

    initial begin
        reset = 1'b1; selector = '0; hold = 1'b0; rr_mode = 1'b0;
        a_din = '0; a_vin = '0; b_din = '0; b_vin = '0;
        ma = mreset(4);
        mb = mreset(3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // Manual capture of channel 2
        selector = 2'd2; a_vin = 4'b0100; a_din = 8'h20;
        b_vin = 3'b100; b_din = 9'b101_000_000;
        cyc();
        check("cap_data", int'(a_dout), 2);
        check("cap_valid", int'(a_vout), 1);
        check("cap_sel", int'(a_sel), 2);
        check("model_cap", ma.data, 2);

        // Memory across misses
        a_vin = 4'b0000; a_din = 8'h10; b_vin = 3'b000;
        repeat (3) cyc();
        check("mem_data", int'(a_dout), 2);
        check("mem_valid", int'(a_vout), 0);
        check("mem_miss", int'(a_miss), 3);
        check("model_miss", ma.miss, 3);

        // Freeze
        hold = 1'b1; selector = 2'd1; a_vin = 4'b1111; a_din = 8'h04; b_vin = 3'b111;
        repeat (2) cyc();
        check("hold_data", int'(a_dout), 2);
        check("hold_valid", int'(a_vout), 0);
        check("hold_sel", int'(a_sel), 2);
        check("hold_miss", int'(a_miss), 3);
        hold = 1'b0;
        cyc();
        check("rel_data", int'(a_dout), 1);
        check("rel_sel", int'(a_sel), 1);
        check("rel_valid", int'(a_vout), 1);

        // Capture 2'b11 then reset mid-run
        selector = 2'd3; a_vin = 4'b1000; a_din = 8'hC0;
        cyc();
        check("pre_rst_data", int'(a_dout), 3);
        async_reset(1'b1);

        // Saturation, and out-of-range selector on the 3-channel instance
        selector = 2'd3; a_vin = 4'b0111; b_vin = 3'b111;
        repeat (5) cyc();
        check("sat_miss", int'(a_miss), 3);
        check("oob_miss", int'(b_miss), 5);
        check("model_sat", ma.miss, 3);
        cyc();
        check("sat_hold", int'(a_miss), 3);

`ifdef MUX_RR_EN
        async_reset(1'b0);
        rr_mode = 1'b1; a_vin = 4'b1011; a_din = 8'b11_10_01_00; b_vin = 3'b101;
        cyc(); check("rr_g0", int'(a_sel), 0);
        cyc(); check("rr_g1", int'(a_sel), 1);
        cyc(); check("rr_g2", int'(a_sel), 3);
        cyc(); check("rr_g3", int'(a_sel), 0);
        a_vin = 4'b0000;
        cyc();
        check("rr_none_valid", int'(a_vout), 0);
        check("rr_none_sel", int'(a_sel), 0);
        a_vin = 4'b1111;
        cyc(); check("rr_ptr_kept", int'(a_sel), 1);
        rr_mode = 1'b0;
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            selector = 2'($urandom_range(0, 3));
            a_din    = 8'($urandom);
            b_din    = 9'($urandom);
            a_vin    = 4'($urandom) & 4'($urandom | 32'h5);
            b_vin    = 3'($urandom);
            hold     = ($urandom_range(0, 7) == 0);
            rr_mode  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                async_reset(1'b0);
            end else begin
                cyc();
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
